button_conditioner: RTL and testbench

Input-side conditioner for the board's push-buttons and slide switches. Synchronises the raw asynchronous `btnC`/`btnL`/`btnR`/`sw` pins to `clk`, debounces each line, and emits single-cycle press strobes. It also holds the registered LED movement mode (cylon / left / right) with a change strobe. It sits between the board pins and the LED pattern/speed logic, which consumes only clean, clock-aligned signals.

---
 rtl/button_conditioner.sv | 59 +++++
 tb/tb_button_conditioner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects board buttons/switches and holds the LED movement mode.
module button_conditioner #(
  parameter logic [23:0] DEBOUNCE_CLKS = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnC,
  input  logic        btnL,
  input  logic        btnR,
  input  logic [15:0] sw,
  output logic [15:0] sw_stable,
  output logic [2:0]  btn_stable,
  output logic [2:0]  press,
  output logic [1:0]  mode,
  output logic        mode_changed
);
  localparam int N = 19;
  logic [N-1:0] raw, s1_q, s2_q, stable_q, stable_d, acc;
  logic [23:0]  cnt_q [N];
  logic [23:0]  cnt_d [N];
  logic [2:0]   press_q, press_d;
  logic [1:0]   mode_q, mode_d;
  logic         mode_changed_q;
  // lanes [2:0] are the buttons {C,R,L}; lanes [18:3] are the switches
  assign raw = {sw, btnC, btnR, btnL};
  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc[i]   = (s2_q[i] != stable_q[i]) && (cnt_q[i] == DEBOUNCE_CLKS - 24'd1);
      cnt_d[i] = (s2_q[i] == stable_q[i] || acc[i]) ? 24'd0 : cnt_q[i] + 24'd1;
    end
    stable_d = stable_q ^ acc;
    press_d  = acc[2:0] & ~stable_q[2:0];
    mode_d   = press_q[2] ? 2'b00 : press_q[1] ? 2'b10 : press_q[0] ? 2'b01 : mode_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q           <= '0;
      s2_q           <= '0;
      stable_q       <= '0;
      press_q        <= '0;
      mode_q         <= 2'b00;
      mode_changed_q <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      s1_q           <= raw;
      s2_q           <= s1_q;
      stable_q       <= stable_d;
      press_q        <= press_d;
      mode_q         <= mode_d;
      mode_changed_q <= mode_d != mode_q;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign sw_stable    = stable_q[18:3];
  assign btn_stable   = stable_q[2:0];
  assign press        = press_q;
  assign mode         = mode_q;
  assign mode_changed = mode_changed_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench with a sliding-window reference model of the debouncer.
module tb_button_conditioner;
  localparam int D = 4;
  logic clk = 0, rst = 1, btnC = 0, btnL = 0, btnR = 0;
  logic [15:0] sw = 0, sw_stable;
  logic [2:0] btn_stable, press;
  logic [1:0] mode;
  logic mode_changed;
  int checks = 0, errors = 0;
  int n_press = 0, n_mc = 0, n_press0 = 0, base;

  button_conditioner #(.DEBOUNCE_CLKS(24'd4)) dut (
    .clk(clk), .rst(rst), .btnC(btnC), .btnL(btnL), .btnR(btnR), .sw(sw),
    .sw_stable(sw_stable), .btn_stable(btn_stable), .press(press),
    .mode(mode), .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a level is accepted once the last D synchronised samples all differ from it.
  logic [20:0] snap_q[$];
  logic [2:0]  press_q[$];
  logic [1:0]  mode_q[$];
  logic [D-1:0] win [19];
  logic [18:0] m_s1 = 0, m_s2 = 0, m_st = 0, m_raw;
  logic [2:0]  m_pr = 0, new_pr;
  logic [1:0]  m_mode = 0, nm;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_st = 0; m_pr = 0; m_mode = 0;
      for (int i = 0; i < 19; i++) win[i] = 0;
      snap_q.delete(); press_q.delete(); mode_q.delete();
    end else begin
      m_raw = {sw, btnC, btnR, btnL};
      nm = m_mode;
      if (m_pr[2]) nm = 2'b00;
      else if (m_pr[1]) nm = 2'b10;
      else if (m_pr[0]) nm = 2'b01;
      if (nm != m_mode) mode_q.push_back(nm);
      m_mode = nm;
      new_pr = 0;
      for (int i = 0; i < 19; i++) begin
        win[i] = {win[i][D-2:0], m_s2[i]};
        if (win[i] == {D{~m_st[i]}}) begin
          if (i < 3 && !m_st[i]) new_pr[i] = 1'b1;
          m_st[i] = ~m_st[i];
        end
      end
      m_pr = new_pr;
      if (new_pr != 0) press_q.push_back(new_pr);
      m_s2 = m_s1;
      m_s1 = m_raw;
      snap_q.push_back({m_mode, m_st[2:0], m_st[18:3]});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (snap_q.size() != 0) chk("levels_mode", {11'd0, mode, btn_stable, sw_stable}, {11'd0, snap_q.pop_front()});
      else begin checks++; errors++; $display("FAIL levels_mode: no expected snapshot at %0t", $time); end
      if (press != 0) begin
        n_press++;
        if (press[0]) n_press0++;
        if (press_q.size() != 0) chk("press", {29'd0, press}, {29'd0, press_q.pop_front()});
        else begin checks++; errors++; $display("FAIL press: got %b expected none at %0t", press, $time); end
      end
      if (mode_changed) begin
        n_mc++;
        if (mode_q.size() != 0) chk("mode_change", {30'd0, mode}, {30'd0, mode_q.pop_front()});
        else begin checks++; errors++; $display("FAIL mode_change: got mode %b expected no change at %0t", mode, $time); end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("reset_outputs", {sw_stable, btn_stable, press, mode, mode_changed}, 0);
    #1 rst = 0;
    tick(3);
    // btnR press from mode 00
    #1 btnR = 1;
    tick(5);
    chk("btnR_not_yet", {29'd0, btn_stable}, 0);
    tick(1);
    chk("btnR_stable", {29'd0, btn_stable}, 3'b010);
    chk("btnR_press", {29'd0, press}, 3'b010);
    tick(1);
    chk("btnR_mode", {29'd0, mode, mode_changed}, 3'b101);
    chk("btnR_press_once", {29'd0, press}, 0);
    tick(1);
    chk("btnR_mc_once", {31'd0, mode_changed}, 0);
    #1 btnR = 0;
    tick(8);
    // short btnL pulses are rejected
    #1 base = n_press + n_mc;
    for (int k = 0; k < 5; k++) begin
      btnL = 1; tick(3); #1 btnL = 0; tick(3); #1;
    end
    tick(6);
    #1 chk("glitch_no_events", n_press + n_mc - base, 0);
    chk("glitch_levels", {27'd0, btn_stable, mode}, {27'd0, 3'b000, 2'b10});
    // go to mode 01, then press all three together
    btnL = 1; tick(8); #1 btnL = 0; tick(8);
    chk("mode_left", {30'd0, mode}, 2'b01);
    #1 {btnC, btnR, btnL} = 3'b111;
    tick(6);
    chk("all_press", {29'd0, press}, 3'b111);
    tick(1);
    chk("all_mode", {29'd0, mode, mode_changed}, 3'b001);
    #1 base = n_press;
    tick(10);
    #1 chk("all_no_restrobe", n_press - base, 0);
    {btnC, btnR, btnL} = 3'b000;
    tick(8);
    // mode 10, release and re-press R
    #1 btnR = 1; tick(8); #1 btnR = 0; tick(8);
    chk("mode_right", {30'd0, mode}, 2'b10);
    #1 btnR = 1;
    tick(6);
    chk("repress_strobe", {29'd0, press}, 3'b010);
    tick(1);
    chk("repress_no_change", {29'd0, mode, mode_changed}, 3'b100);
    #1 btnR = 0;
    tick(8);
    // switches and a single-cycle glitch
    #1 sw = 16'hA5C3;
    tick(5);
    chk("sw_not_yet", {16'd0, sw_stable}, 0);
    tick(1);
    chk("sw_accept", {16'd0, sw_stable}, 16'hA5C3);
    #1 sw[0] = 0;
    tick(1);
    #1 sw[0] = 1;
    tick(8);
    chk("sw_glitch", {16'd0, sw_stable}, 16'hA5C3);
    // asynchronous reset in the middle of a btnL count
    #1 btnL = 1;
    tick(4);
    #2 rst = 1;
    #1 chk("async_reset", {sw_stable, btn_stable, press, mode, mode_changed}, 0);
    tick(1);
    #1 base = n_press0;
    rst = 0;
    tick(12);
    #1 chk("reset_reaccept_press", n_press0 - base, 1);
    chk("reset_reaccept_level", {27'd0, btn_stable, mode}, {27'd0, 3'b001, 2'b01});
    btnL = 0;
    tick(8);
    // randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) btnC = ~btnC;
      if ($urandom_range(0, 3) == 0) btnR = ~btnR;
      if ($urandom_range(0, 3) == 0) btnL = ~btnL;
      sw = sw ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 599) == 0) begin
        #1 rst = 1;
        @(negedge clk);
        #1 rst = 0;
      end
    end
    #1 {btnC, btnR, btnL} = 3'b000;
    tick(20);
    #1 chk("press_drained", press_q.size(), 0);
    chk("mode_drained", mode_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
